// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter, one holding register ahead of the shifter; first START appears two edges after transfer.
// tx_ready drops while the holding register is full; define UART_TX_PARITY_EN to add an even-parity bit.
module uart_tx #(
  parameter int DIVISOR_WIDTH = 16,
  parameter int STOP_BITS     = 1
) (
  input  logic                     int_logic_slow_clock,
  input  logic                     system_reset_in,
  input  logic [DIVISOR_WIDTH-1:0] baud_divisor,
  input  logic [7:0]               tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic                     txd,
  output logic                     tx_busy
);

  localparam logic [DIVISOR_WIDTH-1:0] CNT_ONE = 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                   state, state_nxt;
  logic                     hold_full;
  logic [7:0]               hold_dat;
  logic [7:0]               shift_reg;
  logic [DIVISOR_WIDTH-1:0] div_q;
  logic [DIVISOR_WIDTH-1:0] baud_cnt;
  logic [2:0]               bit_cnt;
  logic                     stop_cnt;
  logic                     load;
  logic                     xfer;
  logic                     bit_end;
  logic                     stop_last;
  logic                     txd_nxt;
`ifdef UART_TX_PARITY_EN
  logic                     parity_bit;
`endif

  assign xfer      = tx_valid & ~hold_full;
  assign tx_ready  = ~hold_full;
  assign tx_busy   = (state != IDLE) | hold_full;
  // Counter runs 0..div_q inclusive, so the all-ones divisor never wraps mid-bit.
  assign bit_end   = (baud_cnt == div_q);
  assign stop_last = (STOP_BITS == 1) || stop_cnt;

  always_ff @(posedge int_logic_slow_clock or posedge system_reset_in) begin
    if (system_reset_in) state <= IDLE;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    txd_nxt   = 1'b1;
    case (state)
      IDLE: begin
        if (hold_full) begin
          load      = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        txd_nxt = 1'b0;
        if (bit_end) state_nxt = DATA;
      end
      DATA: begin
        txd_nxt = shift_reg[0];
        if (bit_end && bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        txd_nxt = parity_bit;
        if (bit_end) state_nxt = STOP;
      end
`endif
      STOP: begin
        if (bit_end && stop_last) begin
          if (hold_full) begin
            load      = 1'b1;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge int_logic_slow_clock or posedge system_reset_in) begin
    if (system_reset_in) begin
      txd       <= 1'b1;
      hold_full <= 1'b0;
      hold_dat  <= 8'h00;
      shift_reg <= 8'h00;
      div_q     <= '0;
      baud_cnt  <= '0;
      bit_cnt   <= 3'd0;
      stop_cnt  <= 1'b0;
    end else begin
      txd <= txd_nxt;
      // xfer and load are mutually exclusive: xfer needs an empty holder, load a full one.
      if (xfer) begin
        hold_full <= 1'b1;
        hold_dat  <= tx_data;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      if (load) begin
        shift_reg <= hold_dat;
        div_q     <= baud_divisor;
        baud_cnt  <= '0;
        bit_cnt   <= 3'd0;
        stop_cnt  <= 1'b0;
      end else if (state != IDLE) begin
        if (bit_end) begin
          baud_cnt <= '0;
          if (state == DATA) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
          end
          if (state == STOP) stop_cnt <= ~stop_cnt;
        end else begin
          baud_cnt <= baud_cnt + CNT_ONE;
        end
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge int_logic_slow_clock or posedge system_reset_in) begin
    if (system_reset_in) parity_bit <= 1'b0;
    else if (load)       parity_bit <= ^hold_dat;
  end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: expected line activity is a per-clock queue of {in_frame, txd} built from the frame format.
// Divisor is only changed while the holding register is empty, so a frame's timing is fixed at its transfer.
module tb_uart_tx;

  localparam int DW = 4;
  localparam int SB = 2;

  logic          int_logic_slow_clock = 1'b0;
  logic          system_reset_in;
  logic [DW-1:0] baud_divisor;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          txd;
  logic          tx_busy;

  int          checks   = 0;
  int          failures = 0;
  logic [1:0]  exp_q[$];
  int          pend     = 0;
  logic        m_ready  = 1'b1;
  logic        took     = 1'b0;

  always #5 int_logic_slow_clock = ~int_logic_slow_clock;

  uart_tx #(.DIVISOR_WIDTH(DW), .STOP_BITS(SB)) u_dut (
    .int_logic_slow_clock(int_logic_slow_clock),
    .system_reset_in     (system_reset_in),
    .baud_divisor        (baud_divisor),
    .tx_data             (tx_data),
    .tx_valid            (tx_valid),
    .tx_ready            (tx_ready),
    .txd                 (txd),
    .tx_busy             (tx_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] b, input int div);
    for (int k = 0; k <= div; k++) exp_q.push_back(2'b10);
    for (int i = 0; i < 8; i++)
      for (int k = 0; k <= div; k++) exp_q.push_back({1'b1, b[i]});
`ifdef UART_TX_PARITY_EN
    for (int k = 0; k <= div; k++) exp_q.push_back({1'b1, ^b});
`endif
    for (int k = 0; k < SB * (div + 1); k++) exp_q.push_back(2'b11);
  endtask

  task automatic cycle();
    logic [1:0] e;
    @(posedge int_logic_slow_clock);
    took = 1'b0;
    if (tx_valid && m_ready && !system_reset_in) begin
      took = 1'b1;
      // New START shows no earlier than two edges after the transfer.
      while (exp_q.size() < 2) exp_q.push_back(2'b01);
      pend = exp_q.size();
      push_frame(tx_data, int'(baud_divisor));
    end
    @(negedge int_logic_slow_clock);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b01;
    if (pend > 0) pend--;
    m_ready = !(pend > 0);
    chk("txd", txd, e[0]);
    chk("tx_ready", tx_ready, m_ready);
    chk("tx_busy", tx_busy, (pend > 0) || (exp_q.size() > 0 && exp_q[0][1]));
  endtask

  task automatic send(input logic [7:0] b);
    tx_valid = 1'b1;
    took = 1'b0;
    for (int i = 0; i < 1000 && !took; i++) begin
      tx_data = m_ready ? b : 8'($urandom);
      cycle();
    end
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    chk("send_timeout", took, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1000 && (exp_q.size() > 0 || pend > 0); i++) cycle();
    chk("idle_busy", tx_busy, 0);
    chk("idle_txd", txd, 1);
  endtask

  task automatic async_reset();
    #1 system_reset_in = 1'b1;
    tx_valid = 1'b0;
    #1;
    chk("rst_txd", txd, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", tx_busy, 0);
    exp_q.delete();
    pend = 0;
    m_ready = 1'b1;
    cycle();
    cycle();
    system_reset_in = 1'b0;
  endtask

  initial begin
    system_reset_in = 1'b1;
    tx_valid        = 1'b0;
    tx_data         = 8'h00;
    baud_divisor    = 4'd3;
    #1;
    chk("por_txd", txd, 1);
    chk("por_ready", tx_ready, 1);
    chk("por_busy", tx_busy, 0);
    cycle();
    cycle();
    system_reset_in = 1'b0;
    cycle();

    send(8'h55);
    wait_idle();

    send(8'hA5);
    send(8'h3C);
    wait_idle();

    baud_divisor = 4'd0;
    send(8'h01);
    wait_idle();

    baud_divisor = 4'hF;
    send(8'($urandom));
    wait_idle();

    baud_divisor = 4'd1;
    send(8'h81);
    send(8'h7E);
    wait_idle();

    baud_divisor = 4'd3;
    send(8'hC3);
    repeat (3) cycle();
    baud_divisor = 4'd7;
    send(8'h96);
    wait_idle();

    // Abort during data bit 3 (a 0 for 0xA5), then a clean frame.
    baud_divisor = 4'd3;
    send(8'hA5);
    repeat (19) cycle();
    chk("pre_rst_txd", txd, 0);
    async_reset();
    send(8'h0F);
    wait_idle();

    for (int n = 0; n < 40; n++) begin
      if (m_ready && ($urandom % 3) == 0) baud_divisor = 4'($urandom_range(0, 3));
      send(8'($urandom));
      repeat ($urandom_range(0, 20)) cycle();
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
